// File: rtl/dqs_wr_gen.sv
// DQS write-strobe generator for one DDR3 lane: preamble, BL8 toggle run, postamble,
// with seamless back-to-back continuation when a new request lands in the postamble.
module dqs_wr_gen #(
    parameter int PREAMBLE_CYCLES  = 1,
    parameter int POSTAMBLE_CYCLES = 1,
    parameter int CNT_WIDTH        = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] nburst_m1,
    output logic [1:0]           dqs_din,
    output logic                 dqs_tin,
    output logic                 busy,
    output logic                 err
);
    localparam int CW = CNT_WIDTH + 2;
    localparam logic [CW-1:0] PRE_LD  = CW'(PREAMBLE_CYCLES - 1);
    localparam logic [CW-1:0] POST_LD = CW'(POSTAMBLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRE, TOGGLE, POST} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] nb_q, nb_d;
    logic                 rej_d;
    logic [1:0]           din_q;
    logic                 tin_q, busy_q, err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nb_q    <= nb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nb_d    = nb_q;
        rej_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    nb_d    = nburst_m1;
                    cnt_d   = PRE_LD;
                    state_d = PRE;
                end
            end
            PRE: begin
                rej_d = start;
                if (cnt_q == '0) begin
                    // 4*(n+1)-1 is n with two ones appended
                    cnt_d   = {nb_q, 2'b11};
                    state_d = TOGGLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TOGGLE: begin
                rej_d = start;
                if (cnt_q == '0) begin
                    cnt_d   = POST_LD;
                    state_d = POST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            POST: begin
                if (start) begin
                    nb_d    = nburst_m1;
                    cnt_d   = {nburst_m1, 2'b11};
                    state_d = TOGGLE;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage decodes the current state, so pin activity trails the state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q  <= 2'b00;
            tin_q  <= 1'b1;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            din_q  <= (state_q == TOGGLE) ? 2'b01 : 2'b00;
            tin_q  <= (state_q == IDLE);
            busy_q <= (state_q != IDLE);
            err_q  <= rej_d;
        end
    end

    assign dqs_din = din_q;
    assign dqs_tin = tin_q;
    assign busy    = busy_q;
    assign err     = err_q;
endmodule

// File: doc/dqs_wr_gen.md
# dqs_wr_gen

Write-strobe pattern generator for one DDR3 DQS lane. It sits directly upstream of the ODDR + differential tristate output wrapper and drives that wrapper's `din[1:0]` and `tin` inputs. Each write request produces the preamble, the toggle run for N back-to-back BL8 bursts, and the postamble. Between requests the pin is released (tristated).

## Interface
Parameters:
- `PREAMBLE_CYCLES`, 1: clk cycles of driven-low DQS before the first toggle (1..4).
- `POSTAMBLE_CYCLES`, 1: clk cycles of driven-low DQS after the last toggle (1..4).
- `CNT_WIDTH`, 6: width of the burst-count input.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: DDR/PHY clock, same clock that feeds the ODDR.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle write request.
- `nburst_m1` input CNT_WIDTH: number of BL8 bursts minus 1, sampled when `start` is accepted.
- `dqs_din` output 2: to ODDR `din`. Bit 0 is the rising-edge data, bit 1 the falling-edge data.
- `dqs_tin` output 1: to OBUFTDS `T`. 1 = tristate.
- `busy` output 1: high in any state other than IDLE.
- `err` output 1: one-cycle pulse when a `start` is rejected.

## Operation
- All outputs are registered. Reset values: `dqs_din`=2'b00, `dqs_tin`=1, `busy`=0, `err`=0, state IDLE, all counters 0.
- States: IDLE, PRE, TOGGLE, POST.
- **IDLE**
  - Outputs: `dqs_tin`=1, `dqs_din`=00.
  - On `start`: latch `nburst_m1`, load the phase counter with PREAMBLE_CYCLES-1, go to PRE.
- **PRE**
  - Outputs: `dqs_tin`=0, `dqs_din`=00.
  - When the counter reaches 0: go to TOGGLE and load the toggle counter with 4*(nburst_m1+1)-1.
  - The toggle counter is CNT_WIDTH+2 bits wide; no overflow is possible.
- **TOGGLE**
  - Outputs: `dqs_tin`=0, `dqs_din`=2'b01 (DQS high on the rising edge, low on the falling edge).
  - When the counter reaches 0: go to POST and load the counter with POSTAMBLE_CYCLES-1.
- **POST**
  - Outputs: `dqs_tin`=0, `dqs_din`=00.
  - When the counter reaches 0: go to IDLE.
  - `start` in any POST cycle (including the last): seamless continuation.
    - Latch the new `nburst_m1`, skip the preamble, and go directly to TOGGLE with the counter reloaded.
    - `dqs_tin` stays 0 throughout.
- Rejected starts:
  - `start` in PRE or TOGGLE is ignored: no state or counter change, and `err`=1 on the next cycle.
  - A `start` in the same cycle as `rst` is lost. Reset wins and `err` stays 0.
- Reset mid-operation: on the cycle after `rst` is sampled high, all outputs return to their reset values. There is no postamble drain.

## Timing
- Latency from `start` sampled at edge k to the first output change:
  - `dqs_tin`=0 and `busy`=1 are visible after edge k+1.
  - Preamble occupies outputs for cycles k+1 .. k+PREAMBLE_CYCLES.
  - Toggle occupies the next 4*(nburst_m1+1) cycles.
  - Postamble occupies the next POSTAMBLE_CYCLES cycles.
  - `dqs_tin` returns to 1 and `busy` returns to 0 in the following cycle.
- Total driven cycles per isolated request: PREAMBLE_CYCLES + 4*(nburst_m1+1) + POSTAMBLE_CYCLES.
- Seamless `start` at POST cycle j: TOGGLE begins on the next cycle. The DQS low gap equals j+1 cycles (min 1).
- `nburst_m1` is don't-care except in the `start` cycle.
- `err` is high for exactly one cycle per rejected `start`.
- No combinational path from any input to any output.

## Test plan
- **Reset defaults:** assert `rst` for 3 cycles → `dqs_tin`=1, `dqs_din`=00, `busy`=0, `err`=0.
- **Single burst:** defaults, `start` with `nburst_m1`=0 → 1 cycle of tin=0/din=00, then 4 cycles of din=01, then 1 cycle of din=00, then tin=1. `busy` is high for exactly 6 cycles.
- **Multi-burst with longer pre/post:** PREAMBLE_CYCLES=2, POSTAMBLE_CYCLES=2, `nburst_m1`=3 → 2 pre cycles, 16 toggle cycles, 2 post cycles; 20 driven cycles total.
- **Seamless back-to-back:** `start`(`nburst_m1`=0), then a second `start`(`nburst_m1`=1) in the single POST cycle → toggles 4, one 00 cycle, toggles 8, post, tristate. `dqs_tin` never rises in between.
- **Rejected start:** `start` during TOGGLE (3rd toggle cycle) → sequence unchanged, `err` pulses 1 cycle, total toggle count still 4.
- **Mid-operation reset:** `rst` in the 2nd toggle cycle → next cycle `dqs_tin`=1, `dqs_din`=00, `busy`=0. A fresh `start` afterwards produces a full normal sequence including the preamble.
